// File: rtl/if_fetch_stage_pkg.sv
// Shared widths, state encodings and helpers for the instruction-fetch stage.
// The optional boot-load path is enabled by defining IF_BOOT_LOAD_EN.
`ifndef IF_FETCH_DEFINES
`define IF_FETCH_DEFINES
`define INST_SIZE 32
`define INST_DEPTH 64
`define IF_PC_W 32
`define IF_ST_LOAD 1'b0
`define IF_ST_RUN 1'b1
`endif

package if_fetch_stage_pkg;
  localparam int IF_AW = $clog2(`INST_DEPTH);
  localparam int IF_IW = `INST_SIZE;

  localparam logic [0:0] IF_ST_LOAD = `IF_ST_LOAD;
  localparam logic [0:0] IF_ST_RUN  = `IF_ST_RUN;

  typedef logic [`IF_PC_W-1:0] pc_t;
  typedef logic [IF_AW-1:0]    waddr_t;
  typedef logic [IF_IW-1:0]    inst_t;

  // Redirect targets are word aligned; the low two bits are simply dropped.
  function automatic pc_t align4(input pc_t addr);
    return addr & ~pc_t'(3);
  endfunction
endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: instruction BRAM port plus the fetch-to-decode handshake
// and the redirect request coming back from execute.
interface if_fetch_stage_if;
  import if_fetch_stage_pkg::*;

  waddr_t bram_addr;
  logic   bram_en;
  logic   bram_we;
  inst_t  bram_din;
  inst_t  bram_dout;
  logic   if_valid;
  pc_t    if_pc;
  inst_t  if_inst;
  logic   id_ready;
  logic   redirect_valid;
  pc_t    redirect_pc;

  modport master (
    output bram_addr, bram_en, bram_we, bram_din, if_valid, if_pc, if_inst,
    input  bram_dout, id_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  bram_addr, bram_en, bram_we, bram_din, if_valid, if_pc, if_inst,
    output bram_dout, id_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/if_pc_reg.sv
// Program counter: redirect mux, alignment and +4 advance on each issued read.
module if_pc_reg
  import if_fetch_stage_pkg::*;
#(
  parameter pc_t RESET_PC = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic advance,
  input  logic redirect_valid,
  input  pc_t  redirect_pc,
  output pc_t  fetch_pc
);
  pc_t pc;

  assign fetch_pc = redirect_valid ? align4(redirect_pc) : pc;

  // Natural 32-bit wrap on the increment is intended.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_PC;
    else if (advance) pc <= fetch_pc + pc_t'(4);
  end
endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: issues one BRAM read per cycle, absorbs its 1-cycle
// latency and presents {pc, inst} to decode. Optional boot loader: IF_BOOT_LOAD_EN.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter pc_t RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  if_fetch_stage_if.master   bus
`ifdef IF_BOOT_LOAD_EN
  ,
  input  logic               ld_valid,
  input  waddr_t             ld_addr,
  input  inst_t              ld_data,
  input  logic               ld_done
`endif
);
  logic [0:0] state;
  logic       run;
  logic       issue;
  logic       rd_pend;
  pc_t        pend_pc;
  pc_t        fetch_pc;

`ifdef IF_BOOT_LOAD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IF_ST_LOAD;
    else if (state == IF_ST_LOAD && ld_done) state <= IF_ST_RUN;
  end
`else
  assign state = IF_ST_RUN;
`endif

  // rst_n gates the issue so the BRAM is idle the instant reset asserts.
  assign run   = rst_n && (state == IF_ST_RUN);
  assign issue = run && (bus.redirect_valid || !rd_pend || bus.id_ready);

  if_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk            (clk),
    .rst_n          (rst_n),
    .advance        (issue),
    .redirect_valid (bus.redirect_valid),
    .redirect_pc    (bus.redirect_pc),
    .fetch_pc       (fetch_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend <= 1'b0;
      pend_pc <= '0;
    end else if (issue) begin
      rd_pend <= 1'b1;
      pend_pc <= fetch_pc;
    end
  end

  always_comb begin
    bus.bram_en   = issue;
    bus.bram_addr = fetch_pc[IF_AW+1:2];
    bus.bram_we   = 1'b0;
    bus.bram_din  = '0;
`ifdef IF_BOOT_LOAD_EN
    if (rst_n && state == IF_ST_LOAD) begin
      bus.bram_en   = ld_valid;
      bus.bram_we   = ld_valid;
      bus.bram_addr = ld_addr;
      bus.bram_din  = ld_valid ? ld_data : '0;
    end
`endif
  end

  // The BRAM holds douta while idle, so a stalled instruction stays stable.
  assign bus.if_valid = rd_pend;
  assign bus.if_pc    = pend_pc;
  assign bus.if_inst  = bus.bram_dout;
endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed self-checking bench for if_fetch_stage paired with a 1-cycle BRAM model.
// Define IF_BOOT_LOAD_EN to also exercise the boot-load path.
`ifndef IF_FETCH_DEFINES
`define IF_FETCH_DEFINES
`define INST_SIZE 32
`define INST_DEPTH 64
`define IF_PC_W 32
`define IF_ST_LOAD 1'b0
`define IF_ST_RUN 1'b1
`endif

module tb_if_fetch_stage;
  import if_fetch_stage_pkg::*;

  localparam inst_t BASE = 32'h1000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total = 0;

  always #5 clk = ~clk;

  if_fetch_stage_if bus();

  inst_t mem [0:`INST_DEPTH-1];
  inst_t dout_q = '0;

`ifdef IF_BOOT_LOAD_EN
  logic   ld_valid = 1'b0;
  logic   ld_done = 1'b0;
  waddr_t ld_addr = '0;
  inst_t  ld_data = '0;
  int     we_count = 0;
`endif

  if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef IF_BOOT_LOAD_EN
    ,
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .ld_done  (ld_done)
`endif
  );

  // Read-first BRAM: douta updates only on enabled cycles.
  always @(posedge clk) begin
    if (bus.bram_en) begin
`ifdef IF_BOOT_LOAD_EN
      if (bus.bram_we) mem[bus.bram_addr] <= bus.bram_din;
      if (bus.bram_we) we_count <= we_count + 1;
`endif
      dout_q <= mem[bus.bram_addr];
    end
  end
  assign bus.bram_dout = dout_q;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
`ifdef IF_BOOT_LOAD_EN
    ld_done = 1'b1;
    step();
    ld_done = 1'b0;
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.id_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    repeat (2) step();
    total++; if (bus.if_valid !== 1'b0) $display("[TB] FAIL reset_valid got %b want 0", bus.if_valid); else passed++;
    total++; if (bus.bram_en !== 1'b0) $display("[TB] FAIL reset_en got %b want 0", bus.bram_en); else passed++;
    total++; if (bus.if_pc !== 32'h0) $display("[TB] FAIL reset_pc got %h want 0", bus.if_pc); else passed++;
    total++; if (bus.bram_we !== 1'b0) $display("[TB] FAIL reset_we got %b want 0", bus.bram_we); else passed++;
    total++; if (bus.bram_din !== '0) $display("[TB] FAIL reset_din got %h want 0", bus.bram_din); else passed++;
    release_reset();
    #1;
    total++; if (bus.bram_en !== 1'b1) $display("[TB] FAIL first_issue_en got %b want 1", bus.bram_en); else passed++;
    total++; if (bus.bram_addr !== '0) $display("[TB] FAIL first_issue_addr got %h want 0", bus.bram_addr); else passed++;
    total++; if (bus.if_valid !== 1'b0) $display("[TB] FAIL first_issue_valid got %b want 0", bus.if_valid); else passed++;
  endtask

  task automatic test_stream();
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (bus.if_valid !== 1'b1) $display("[TB] FAIL stream_valid k=%0d got %b want 1", k, bus.if_valid); else passed++;
      total++; if (bus.if_pc !== pc_t'(4 * k)) $display("[TB] FAIL stream_pc k=%0d got %h want %h", k, bus.if_pc, 4 * k); else passed++;
      total++; if (bus.if_inst !== BASE + inst_t'(k)) $display("[TB] FAIL stream_inst k=%0d got %h want %h", k, bus.if_inst, BASE + inst_t'(k)); else passed++;
    end
  endtask

  task automatic test_stall();
    bus.id_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.bram_en !== 1'b0) $display("[TB] FAIL stall_en i=%0d got %b want 0", i, bus.bram_en); else passed++;
      total++; if (bus.if_pc !== 32'h8) $display("[TB] FAIL stall_pc i=%0d got %h want 8", i, bus.if_pc); else passed++;
      total++; if (bus.if_inst !== BASE + 32'h2) $display("[TB] FAIL stall_inst i=%0d got %h want %h", i, bus.if_inst, BASE + 32'h2); else passed++;
      step();
    end
    bus.id_ready = 1'b1;
    #1;
    total++; if (bus.if_pc !== 32'h8) $display("[TB] FAIL accept_pc got %h want 8", bus.if_pc); else passed++;
    total++; if (bus.bram_en !== 1'b1) $display("[TB] FAIL resume_en got %b want 1", bus.bram_en); else passed++;
    total++; if (bus.bram_addr !== waddr_t'(3)) $display("[TB] FAIL resume_addr got %h want 3", bus.bram_addr); else passed++;
    step();
    total++; if (bus.if_pc !== 32'hC) $display("[TB] FAIL resume_pc got %h want c", bus.if_pc); else passed++;
    total++; if (bus.if_inst !== BASE + 32'h3) $display("[TB] FAIL resume_inst got %h want %h", bus.if_inst, BASE + 32'h3); else passed++;
    step();
    total++; if (bus.if_pc !== 32'h10) $display("[TB] FAIL next_pc got %h want 10", bus.if_pc); else passed++;
  endtask

  task automatic test_redirect();
    bus.id_ready = 1'b0;
    #1;
    total++; if (bus.bram_en !== 1'b0) $display("[TB] FAIL redir_stall_en got %b want 0", bus.bram_en); else passed++;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h43;
    #1;
    total++; if (bus.bram_en !== 1'b1) $display("[TB] FAIL redir_en got %b want 1", bus.bram_en); else passed++;
    total++; if (bus.bram_addr !== waddr_t'(16)) $display("[TB] FAIL redir_addr got %h want 10", bus.bram_addr); else passed++;
    step();
    bus.redirect_valid = 1'b0;
    bus.id_ready = 1'b1;
    total++; if (bus.if_pc !== 32'h40) $display("[TB] FAIL redir_pc got %h want 40", bus.if_pc); else passed++;
    total++; if (bus.if_inst !== BASE + 32'h10) $display("[TB] FAIL redir_inst got %h want %h", bus.if_inst, BASE + 32'h10); else passed++;
    step();
    total++; if (bus.if_pc !== 32'h44) $display("[TB] FAIL redir_next_pc got %h want 44", bus.if_pc); else passed++;
    total++; if (bus.if_inst !== BASE + 32'h11) $display("[TB] FAIL redir_next_inst got %h want %h", bus.if_inst, BASE + 32'h11); else passed++;
    // Redirect coinciding with a transfer: target follows immediately.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h8;
    step();
    bus.redirect_valid = 1'b0;
    total++; if (bus.if_pc !== 32'h8) $display("[TB] FAIL redir_xfer_pc got %h want 8", bus.if_pc); else passed++;
    total++; if (bus.if_inst !== BASE + 32'h2) $display("[TB] FAIL redir_xfer_inst got %h want %h", bus.if_inst, BASE + 32'h2); else passed++;
  endtask

  task automatic test_wrap();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = pc_t'(4 * `INST_DEPTH - 4);
    step();
    bus.redirect_valid = 1'b0;
    #1;
    total++; if (bus.if_inst !== BASE + inst_t'(`INST_DEPTH - 1)) $display("[TB] FAIL wrap_last_inst got %h want %h", bus.if_inst, BASE + inst_t'(`INST_DEPTH - 1)); else passed++;
    total++; if (bus.bram_addr !== '0) $display("[TB] FAIL wrap_addr got %h want 0", bus.bram_addr); else passed++;
    step();
    total++; if (bus.if_pc !== pc_t'(4 * `INST_DEPTH)) $display("[TB] FAIL wrap_pc got %h want %h", bus.if_pc, 4 * `INST_DEPTH); else passed++;
    total++; if (bus.if_inst !== BASE) $display("[TB] FAIL wrap_inst got %h want %h", bus.if_inst, BASE); else passed++;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    step();
    bus.redirect_valid = 1'b0;
    total++; if (bus.if_pc !== 32'hFFFF_FFFC) $display("[TB] FAIL wrap32_top_pc got %h want fffffffc", bus.if_pc); else passed++;
    step();
    total++; if (bus.if_pc !== 32'h0) $display("[TB] FAIL wrap32_pc got %h want 0", bus.if_pc); else passed++;
    total++; if (bus.if_inst !== BASE) $display("[TB] FAIL wrap32_inst got %h want %h", bus.if_inst, BASE); else passed++;
  endtask

  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus.if_valid !== 1'b0) $display("[TB] FAIL areset_valid got %b want 0", bus.if_valid); else passed++;
    total++; if (bus.bram_en !== 1'b0) $display("[TB] FAIL areset_en got %b want 0", bus.bram_en); else passed++;
    total++; if (bus.if_pc !== 32'h0) $display("[TB] FAIL areset_pc got %h want 0", bus.if_pc); else passed++;
    step();
    release_reset();
    #1;
    total++; if (bus.bram_en !== 1'b1 || bus.bram_addr !== '0) $display("[TB] FAIL restart_issue got en=%b addr=%h want en=1 addr=0", bus.bram_en, bus.bram_addr); else passed++;
    step();
    total++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0) $display("[TB] FAIL restart_pc got v=%b pc=%h want v=1 pc=0", bus.if_valid, bus.if_pc); else passed++;
    total++; if (bus.if_inst !== BASE) $display("[TB] FAIL restart_inst got %h want %h", bus.if_inst, BASE); else passed++;
    step();
    total++; if (bus.if_pc !== 32'h4) $display("[TB] FAIL restart_next_pc got %h want 4", bus.if_pc); else passed++;
  endtask

`ifdef IF_BOOT_LOAD_EN
  task automatic test_boot_load();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    we_count = 0;
    for (int k = 0; k < 4; k++) begin
      ld_valid = 1'b1;
      ld_addr = waddr_t'(k);
      ld_data = 32'hA000_0000 + inst_t'(k);
      #1;
      total++; if (bus.bram_we !== 1'b1 || bus.if_valid !== 1'b0) $display("[TB] FAIL load_we k=%0d got we=%b v=%b want we=1 v=0", k, bus.bram_we, bus.if_valid); else passed++;
      step();
    end
    ld_valid = 1'b0;
    ld_done = 1'b1;
    step();
    ld_done = 1'b0;
    #1;
    total++; if (we_count !== 4) $display("[TB] FAIL load_count got %0d want 4", we_count); else passed++;
    total++; if (bus.bram_en !== 1'b1 || bus.bram_addr !== '0) $display("[TB] FAIL load_first_issue got en=%b addr=%h want en=1 addr=0", bus.bram_en, bus.bram_addr); else passed++;
    for (int k = 0; k < 4; k++) begin
      step();
      total++; if (bus.if_inst !== 32'hA000_0000 + inst_t'(k)) $display("[TB] FAIL load_fetch k=%0d got %h want %h", k, bus.if_inst, 32'hA000_0000 + inst_t'(k)); else passed++;
    end
  endtask
`endif

  initial begin
    for (int k = 0; k < `INST_DEPTH; k++) mem[k] = BASE + inst_t'(k);
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_async_reset();
`ifdef IF_BOOT_LOAD_EN
    test_boot_load();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
